// File: rtl/tcdm_bank_responder_pkg.sv
// Shared widths, the request record and the byte-lane merge helper for the
// TCDM bank responder.
package tcdm_resp_package;

  localparam int TCDM_DATA_W = 32;
  localparam int TCDM_BE_W   = 4;

  typedef struct packed {
    logic [TCDM_DATA_W-1:0] add;
    logic                   wen;
    logic [TCDM_BE_W-1:0]   be;
    logic [TCDM_DATA_W-1:0] data;
  } tcdm_req_t;

  // Replace only the lanes whose byte enable is set
  function automatic logic [TCDM_DATA_W-1:0] apply_be(
    input logic [TCDM_DATA_W-1:0] old_word,
    input logic [TCDM_DATA_W-1:0] new_word,
    input logic [TCDM_BE_W-1:0]   be
  );
    logic [TCDM_DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < TCDM_BE_W; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tcdm_bank_responder_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among MP requesters, scanning from a
// pointer that moves just past the last winner.
module tcdm_rr_arbiter #(
  parameter int  MP = 4,
  localparam int PW = (MP > 1) ? $clog2(MP) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic [MP-1:0] req_i,
  output logic [MP-1:0] gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          gnt_any_o
);

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] cand_s;
  logic [MP-1:0] gnt_s;
  logic [PW-1:0] idx_s;
  logic          any_s;

  // Scan from the pointer; the first requester found wins
  always_comb begin
    gnt_s  = {MP{1'b0}};
    idx_s  = {PW{1'b0}};
    any_s  = 1'b0;
    cand_s = {PW{1'b0}};
    if (!rst_i && !stall_i) begin
      for (int i = 0; i < MP; i++) begin
        cand_s = PW'((int'(ptr_r) + i) % MP);
        if (req_i[cand_s] && !any_s) begin
          any_s         = 1'b1;
          gnt_s[cand_s] = 1'b1;
          idx_s         = cand_s;
        end else begin
          any_s = any_s;
        end
      end
    end else begin
      any_s = 1'b0;
    end
  end

  // Pointer moves past the granted port and holds when nothing is granted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_r <= {PW{1'b0}};
    end else if (any_s) begin
      ptr_r <= (idx_s == PW'(MP - 1)) ? {PW{1'b0}} : idx_s + PW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign gnt_o     = gnt_s;
  assign gnt_idx_o = idx_s;
  assign gnt_any_o = any_s;

endmodule

// File: rtl/tcdm_bank_responder.sv
// Single-port TCDM memory bank shared by MP ports: round-robin grant,
// byte-masked writes, one-cycle response carrying the read or post-write word.
module tcdm_bank_responder
  import tcdm_resp_package::*;
#(
  parameter int MP    = 4,
  parameter int DEPTH = 1024
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             stall_i,
  input  logic [MP-1:0]                    tcdm_req_i,
  output logic [MP-1:0]                    tcdm_gnt_o,
  input  logic [MP-1:0][TCDM_DATA_W-1:0]   tcdm_add_i,
  input  logic [MP-1:0]                    tcdm_wen_i,
  input  logic [MP-1:0][TCDM_BE_W-1:0]     tcdm_be_i,
  input  logic [MP-1:0][TCDM_DATA_W-1:0]   tcdm_data_i,
  output logic [MP-1:0][TCDM_DATA_W-1:0]   tcdm_r_data_o,
  output logic [MP-1:0]                    tcdm_r_valid_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (MP > 1) ? $clog2(MP) : 1;

  logic [MP-1:0]                  gnt_s;
  logic [PW-1:0]                  gnt_idx_s;
  logic                           gnt_any_s;
  tcdm_req_t                      sel_req_s;
  logic [AW-1:0]                  word_idx_s;
  logic [TCDM_DATA_W-1:0]         rd_word_s;
  logic [TCDM_DATA_W-1:0]         resp_word_s;
  logic                           unused_addr_s;
  logic [TCDM_DATA_W-1:0]         mem_r [DEPTH];
  logic [MP-1:0]                  valid_r;
  logic [MP-1:0][TCDM_DATA_W-1:0] data_r;

  tcdm_rr_arbiter #(.MP(MP)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .stall_i   (stall_i),
    .req_i     (tcdm_req_i),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s),
    .gnt_any_o (gnt_any_s)
  );

  assign tcdm_gnt_o = gnt_s;

  // Route the winning port's request to the bank and form the response word
  always_comb begin
    sel_req_s.add  = tcdm_add_i[gnt_idx_s];
    sel_req_s.wen  = tcdm_wen_i[gnt_idx_s];
    sel_req_s.be   = tcdm_be_i[gnt_idx_s];
    sel_req_s.data = tcdm_data_i[gnt_idx_s];
    word_idx_s     = sel_req_s.add[AW+1:2];
    rd_word_s      = mem_r[word_idx_s];
    if (sel_req_s.wen) begin
      resp_word_s = rd_word_s;
    end else begin
      resp_word_s = apply_be(rd_word_s, sel_req_s.data, sel_req_s.be);
    end
  end

  // Byte offset and bits above the bank alias away
  assign unused_addr_s = ^{sel_req_s.add[TCDM_DATA_W-1:AW+2], sel_req_s.add[1:0]};

  // Bank write; no grant exists during reset so contents are never disturbed
  always_ff @(posedge clk_i) begin
    if (gnt_any_s && !sel_req_s.wen) begin
      mem_r[word_idx_s] <= resp_word_s;
    end
  end

  // Response pulse one cycle after the grant; idle ports keep their last word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= {MP{1'b0}};
      data_r  <= {(MP*TCDM_DATA_W){1'b0}};
    end else begin
      valid_r <= gnt_s;
      if (gnt_any_s) begin
        data_r[gnt_idx_s] <= resp_word_s;
      end
    end
  end

  // Reset also masks a response that was already due this cycle
  assign tcdm_r_valid_o = rst_i ? {MP{1'b0}} : valid_r;
  assign tcdm_r_data_o  = rst_i ? {(MP*TCDM_DATA_W){1'b0}} : data_r;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench for tcdm_bank_responder with a reference memory and a
// response scoreboard filled at grant time and drained on r_valid.
module tb_tcdm_bank_responder;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stall = 1'b0;
  logic [3:0]       req = 4'd0;
  logic [3:0]       gnt;
  logic [3:0][31:0] add = '0;
  logic [3:0]       wen = 4'hF;
  logic [3:0][3:0]  be = '0;
  logic [3:0][31:0] data = '0;
  logic [3:0][31:0] r_data;
  logic [3:0]       r_valid;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [0:1023];
  int          sb_port [$];
  logic [31:0] sb_data [$];

  tcdm_bank_responder #(.MP(4), .DEPTH(1024)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .tcdm_req_i     (req),
    .tcdm_gnt_o     (gnt),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be),
    .tcdm_data_i    (data),
    .tcdm_r_data_o  (r_data),
    .tcdm_r_valid_o (r_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check grant, model it, then check the response after the edge
  task automatic step(input logic [3:0] exp_gnt, input logic next_rst, input string tag);
    logic [3:0]  g;
    int          k;
    int          p;
    logic [9:0]  wi;
    logic [31:0] d;
    #2;
    g = gnt;
    chk({tag, " gnt"}, {124'd0, g}, {124'd0, exp_gnt});
    if (g != 4'd0) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (g[i]) k = i;
      wi = add[k][11:2];
      if (!wen[k]) model[wi] = merge(model[wi], data[k], be[k]);
      sb_port.push_back(k);
      sb_data.push_back(model[wi]);
    end
    @(posedge clk);
    #1;
    rst = next_rst;
    #1;
    if (rst) begin
      chk({tag, " rst valid"}, {124'd0, r_valid}, 128'd0);
      chk({tag, " rst data"}, r_data, 128'd0);
      sb_port.delete();
      sb_data.delete();
    end else if (sb_port.size() > 0) begin
      p = sb_port.pop_front();
      d = sb_data.pop_front();
      chk({tag, " valid"}, {124'd0, r_valid}, {124'd0, 4'b0001 << p});
      chk({tag, " data"}, {96'd0, r_data[p]}, {96'd0, d});
    end else begin
      chk({tag, " idle valid"}, {124'd0, r_valid}, 128'd0);
    end
  endtask

  task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input string tag);
    req[p] = 1'b1; wen[p] = w; add[p] = a; be[p] = b; data[p] = d;
    step(4'b0001 << p, 1'b0, tag);
    req[p] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      add[i]  = 32'h100 + 32'(16 * i);
      wen[i]  = 1'b0;
      be[i]   = 4'hF;
      data[i] = 32'hA000_0000 + 32'(i);
    end
    req = 4'hF;
    step(4'd0, 1'b1, "reset0");
    step(4'd0, 1'b0, "reset1");

    for (int c = 0; c < 8; c++) step(4'b0001 << (c % 4), 1'b0, $sformatf("rr%0d", c));
    req = 4'd0;

    issue(0, 1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF, "wr10");
    issue(0, 1'b1, 32'h10, 4'hF, 32'h0, "rd10");
    chk("rd10 value", {96'd0, r_data[0]}, {96'd0, 32'hDEAD_BEEF});
    chk("port1 hold", {96'd0, r_data[1]}, {96'd0, 32'hA000_0001});

    issue(0, 1'b0, 32'h20, 4'hF, 32'h1122_3344, "wr20a");
    issue(0, 1'b0, 32'h20, 4'h5, 32'hAABB_CCDD, "wr20b");
    issue(0, 1'b1, 32'h20, 4'hF, 32'h0, "rd20");
    chk("rd20 value", {96'd0, r_data[0]}, {96'd0, 32'h11BB_33DD});

    issue(0, 1'b0, 32'h0000_0004, 4'hF, 32'h5A5A_5A5A, "wr_alias");
    issue(0, 1'b1, 32'h0000_1004, 4'hF, 32'h0, "rd_alias");
    chk("alias value", {96'd0, r_data[0]}, {96'd0, 32'h5A5A_5A5A});

    req[2] = 1'b1; wen[2] = 1'b1; add[2] = 32'h10; be[2] = 4'hF;
    stall = 1'b1;
    step(4'd0, 1'b0, "stall c1");
    step(4'd0, 1'b0, "stall c2");
    step(4'd0, 1'b0, "stall c3");
    stall = 1'b0;
    step(4'b0100, 1'b0, "stall c4");
    req[2] = 1'b0;
    step(4'd0, 1'b0, "stall c5");
    chk("stall rdata", {96'd0, r_data[2]}, {96'd0, 32'hDEAD_BEEF});

    req[1] = 1'b1; wen[1] = 1'b1; add[1] = 32'h110;
    step(4'b0010, 1'b1, "rst resp");
    req[1] = 1'b0;
    req[0] = 1'b1; wen[0] = 1'b1; add[0] = 32'h100;
    req[3] = 1'b1; wen[3] = 1'b1; add[3] = 32'h130;
    step(4'd0, 1'b0, "rst hold");
    step(4'b0001, 1'b0, "post rst p0");
    req[0] = 1'b0;
    step(4'b1000, 1'b0, "post rst p3");
    req[3] = 1'b0;
    chk("post rst p0 data", {96'd0, r_data[0]}, {96'd0, 32'hA000_0000});
    chk("post rst p3 data", {96'd0, r_data[3]}, {96'd0, 32'hA000_0003});
    chk("sb drained", 128'(sb_port.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
